// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the RV32 decode/control stage: opcode constants,
// control-field encodings and the packed control bundle that travels from the
// combinational decoder into the E-stage register.
// Optional feature macro: DECODE_MULDIV_EN (M-extension encodings).
// -----------------------------------------------------------------------------
package decode_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [4:0] {
      ALU_ADD    = 5'b00000,
      ALU_SUB    = 5'b00001,
      ALU_AND    = 5'b00010,
      ALU_OR     = 5'b00011,
      ALU_SLT    = 5'b00101,
      ALU_SLL    = 5'b00110,
      ALU_SRL    = 5'b00111,
      ALU_XOR    = 5'b01000,
      ALU_SLTU   = 5'b01001,
      ALU_SRA    = 5'b01010,
      ALU_LUI    = 5'b01011,
      ALU_AUIPC  = 5'b01100,
      ALU_MUL    = 5'b10000,
      ALU_MULH   = 5'b10001,
      ALU_MULHSU = 5'b10010,
      ALU_MULHU  = 5'b10011,
      ALU_DIV    = 5'b10100,
      ALU_DIVU   = 5'b10101,
      ALU_REM    = 5'b10110,
      ALU_REMU   = 5'b10111
   } alu_ctrl_t;

   typedef enum logic [2:0] {
      IMM_NONE = 3'b000,
      IMM_I    = 3'b001,
      IMM_S    = 3'b010,
      IMM_B    = 3'b011,
      IMM_U    = 3'b100,
      IMM_J    = 3'b101
   } imm_src_t;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_t;

   typedef enum logic [1:0] {
      ST_WORD = 2'b00,
      ST_HALF = 2'b01,
      ST_BYTE = 2'b10
   } store_src_t;

   typedef struct packed {
      logic        reg_write;
      logic        mem_write;
      logic        jump;
      logic        branch;
      logic        alu_src;
      logic        alu_src_a;
      logic        sum_src;
      logic        illegal;
      result_src_t result_src;
      imm_src_t    imm_src;
      alu_ctrl_t   alu_ctrl;
      store_src_t  store_src;
      logic [2:0]  type_branch;
      logic [2:0]  load_part;
   } ctrl_bundle_t;

   // Store width from funct3 (000 byte, 001 half, 010 word).
   function automatic store_src_t store_src_of(input logic [2:0] f3);
      case (f3)
         3'b000:  return ST_BYTE;
         3'b001:  return ST_HALF;
         default: return ST_WORD;
      endcase
   endfunction

endpackage

// File: rtl/decode_ctrl_pipe_comb.sv
// -----------------------------------------------------------------------------
// decode_comb
// Purely combinational RV32 instruction decoder.
//   i_instr   : 32-bit instruction word
//   o_ctrl    : decoded control bundle (all-zero except illegal=1 on bad input)
//   o_is_mul  : legal MUL* encoding (only with DECODE_MULDIV_EN)
//   o_is_div  : legal DIV*/REM* encoding (only with DECODE_MULDIV_EN)
// Optional feature macro: DECODE_MULDIV_EN.
// -----------------------------------------------------------------------------
module decode_comb
   import decode_pkg::*;
(
   input  logic [31:0]  i_instr,
   output ctrl_bundle_t o_ctrl,
   output logic         o_is_mul,
   output logic         o_is_div
);

   logic [6:0]   w_op;
   logic [2:0]   w_f3;
   logic [6:0]   w_f7;
   logic         w_bad;
   logic         w_mul;
   logic         w_div;
   ctrl_bundle_t w_raw;
   logic         w_unused_fields;

   assign w_op = i_instr[6:0];
   assign w_f3 = i_instr[14:12];
   assign w_f7 = i_instr[31:25];

   // Register specifiers are consumed by the register file, not here.
   assign w_unused_fields = ^{i_instr[24:15], i_instr[11:7]};

   always_comb begin
      w_raw = '0;
      w_bad = 1'b0;
      w_mul = 1'b0;
      w_div = 1'b0;
      case (w_op)
         OP_R: begin
            w_raw.reg_write = 1'b1;
            if (w_f7 == F7_BASE) begin
               case (w_f3)
                  3'b000:  w_raw.alu_ctrl = ALU_ADD;
                  3'b001:  w_raw.alu_ctrl = ALU_SLL;
                  3'b010:  w_raw.alu_ctrl = ALU_SLT;
                  3'b011:  w_raw.alu_ctrl = ALU_SLTU;
                  3'b100:  w_raw.alu_ctrl = ALU_XOR;
                  3'b101:  w_raw.alu_ctrl = ALU_SRL;
                  3'b110:  w_raw.alu_ctrl = ALU_OR;
                  default: w_raw.alu_ctrl = ALU_AND;
               endcase
            end else if (w_f7 == F7_ALT && w_f3 == 3'b000) begin
               w_raw.alu_ctrl = ALU_SUB;
            end else if (w_f7 == F7_ALT && w_f3 == 3'b101) begin
               w_raw.alu_ctrl = ALU_SRA;
`ifdef DECODE_MULDIV_EN
            end else if (w_f7 == F7_MULDIV) begin
               // MUL..REMU map to 10000..10111 in funct3 order.
               w_raw.alu_ctrl = alu_ctrl_t'({2'b10, w_f3});
               w_mul = ~w_f3[2];
               w_div = w_f3[2];
`endif
            end else begin
               w_bad = 1'b1;
            end
         end
         OP_I: begin
            w_raw.reg_write = 1'b1;
            w_raw.alu_src   = 1'b1;
            w_raw.imm_src   = IMM_I;
            case (w_f3)
               3'b000: w_raw.alu_ctrl = ALU_ADD;
               3'b010: w_raw.alu_ctrl = ALU_SLT;
               3'b011: w_raw.alu_ctrl = ALU_SLTU;
               3'b100: w_raw.alu_ctrl = ALU_XOR;
               3'b110: w_raw.alu_ctrl = ALU_OR;
               3'b111: w_raw.alu_ctrl = ALU_AND;
               3'b001: begin
                  w_raw.alu_ctrl = ALU_SLL;
                  w_bad = (w_f7 != F7_BASE);
               end
               default: begin
                  if (w_f7 == F7_BASE)     w_raw.alu_ctrl = ALU_SRL;
                  else if (w_f7 == F7_ALT) w_raw.alu_ctrl = ALU_SRA;
                  else                     w_bad = 1'b1;
               end
            endcase
         end
         OP_LOAD: begin
            w_raw.reg_write  = 1'b1;
            w_raw.alu_src    = 1'b1;
            w_raw.imm_src    = IMM_I;
            w_raw.result_src = RES_MEM;
            w_raw.alu_ctrl   = ALU_ADD;
            w_raw.load_part  = w_f3;
            w_bad = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
         end
         OP_STORE: begin
            w_raw.mem_write = 1'b1;
            w_raw.alu_src   = 1'b1;
            w_raw.imm_src   = IMM_S;
            w_raw.alu_ctrl  = ALU_ADD;
            w_raw.store_src = store_src_of(w_f3);
            w_bad = (w_f3 > 3'b010);
         end
         OP_BRANCH: begin
            w_raw.branch      = 1'b1;
            w_raw.imm_src     = IMM_B;
            w_raw.type_branch = w_f3;
            case (w_f3)
               3'b000, 3'b001: w_raw.alu_ctrl = ALU_ADD;
               3'b100, 3'b101: w_raw.alu_ctrl = ALU_SLT;
               3'b110, 3'b111: w_raw.alu_ctrl = ALU_SLTU;
               default:        w_bad = 1'b1;
            endcase
         end
         OP_LUI: begin
            w_raw.reg_write = 1'b1;
            w_raw.alu_src   = 1'b1;
            w_raw.imm_src   = IMM_U;
            w_raw.alu_ctrl  = ALU_LUI;
         end
         OP_AUIPC: begin
            // Operand A is the PC for AUIPC.
            w_raw.reg_write = 1'b1;
            w_raw.alu_src   = 1'b1;
            w_raw.alu_src_a = 1'b1;
            w_raw.imm_src   = IMM_U;
            w_raw.alu_ctrl  = ALU_AUIPC;
         end
         OP_JAL: begin
            w_raw.reg_write  = 1'b1;
            w_raw.jump       = 1'b1;
            w_raw.imm_src    = IMM_J;
            w_raw.result_src = RES_PC4;
         end
         OP_JALR: begin
            // Target adder uses rs1 instead of PC.
            w_raw.reg_write  = 1'b1;
            w_raw.jump       = 1'b1;
            w_raw.alu_src    = 1'b1;
            w_raw.sum_src    = 1'b1;
            w_raw.imm_src    = IMM_I;
            w_raw.result_src = RES_PC4;
            w_bad = (w_f3 != 3'b000);
         end
         default: w_bad = 1'b1;
      endcase
      if (i_instr[1:0] != 2'b11) w_bad = 1'b1;
   end

   // An illegal word collapses to a clean all-zero bundle with only the flag set.
   always_comb begin
      o_ctrl   = w_raw;
      o_is_mul = w_mul;
      o_is_div = w_div;
      if (w_bad) begin
         o_ctrl         = '0;
         o_ctrl.illegal = 1'b1;
         o_is_mul       = 1'b0;
         o_is_div       = 1'b0;
      end
   end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// decode_ctrl_pipe
// Registered D->E control stage of the RV32 pipeline with valid/ready
// handshake, stall/flush handling and illegal-instruction flagging.
//   clk, rst_n          : clock, asynchronous active-low reset
//   instr_i/_valid_i    : instruction word from IF/ID and its valid
//   instr_ready_o       : stage accepts instr_i this cycle
//   stall_i / flush_i   : hold E register / kill D contents (flush wins)
//   valid_e, *_e        : registered E-stage control bundle
//   muldiv_busy_o       : multi-cycle M op still occupying execute
// Optional feature macro: DECODE_MULDIV_EN (M-extension decode plus a 4-bit
// occupancy counter loaded with MUL_LAT-1 / DIV_LAT-1 on accept).
// -----------------------------------------------------------------------------
module decode_ctrl_pipe
   import decode_pkg::*;
#(
   parameter int MUL_LAT = 2,
   parameter int DIV_LAT = 8
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr_i,
   input  logic        instr_valid_i,
   output logic        instr_ready_o,
   input  logic        stall_i,
   input  logic        flush_i,
   output logic        valid_e,
   output logic        reg_write_e,
   output logic        mem_write_e,
   output logic        jump_e,
   output logic        branch_e,
   output logic        alu_src_e,
   output logic        alu_src_a_e,
   output logic        sum_src_e,
   output logic        illegal_e,
   output logic [1:0]  result_src_e,
   output logic [2:0]  imm_src_e,
   output logic [4:0]  alu_ctrl_e,
   output logic [1:0]  store_src_e,
   output logic [2:0]  type_branch_e,
   output logic [2:0]  load_part_e,
   output logic        muldiv_busy_o
);

   localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);
   localparam logic [3:0] DIV_LOAD = 4'(DIV_LAT - 1);

   ctrl_bundle_t w_ctrl;
   logic         w_is_mul;
   logic         w_is_div;
   logic         w_busy;
   logic         w_accept;

   ctrl_bundle_t r_ctrl;
   logic         r_valid;

   decode_comb u_decode (
      .i_instr  (instr_i),
      .o_ctrl   (w_ctrl),
      .o_is_mul (w_is_mul),
      .o_is_div (w_is_div)
   );

   assign instr_ready_o = ~stall_i & ~w_busy;
   assign w_accept      = instr_valid_i & instr_ready_o;

   // D -> E register boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
      end else if (flush_i) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
      end else if (!stall_i) begin
         r_valid <= w_accept;
         r_ctrl  <= w_accept ? w_ctrl : '0;
      end
   end

`ifdef DECODE_MULDIV_EN
   logic [3:0] r_busy_cnt;

   // Occupancy counter: only ever loaded when idle, since accept needs !busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy_cnt <= 4'd0;
      end else if (flush_i) begin
         r_busy_cnt <= 4'd0;
      end else if (w_accept && w_is_div) begin
         r_busy_cnt <= DIV_LOAD;
      end else if (w_accept && w_is_mul) begin
         r_busy_cnt <= MUL_LOAD;
      end else if (!stall_i && (r_busy_cnt != 4'd0)) begin
         r_busy_cnt <= r_busy_cnt - 4'd1;
      end
   end

   assign w_busy = (r_busy_cnt != 4'd0);
`else
   logic w_unused_muldiv;
   assign w_unused_muldiv = w_is_mul | w_is_div | (|MUL_LOAD) | (|DIV_LOAD);
   assign w_busy = 1'b0;
`endif

   assign muldiv_busy_o = w_busy;
   assign valid_e       = r_valid;
   assign reg_write_e   = r_ctrl.reg_write;
   assign mem_write_e   = r_ctrl.mem_write;
   assign jump_e        = r_ctrl.jump;
   assign branch_e      = r_ctrl.branch;
   assign alu_src_e     = r_ctrl.alu_src;
   assign alu_src_a_e   = r_ctrl.alu_src_a;
   assign sum_src_e     = r_ctrl.sum_src;
   assign illegal_e     = r_ctrl.illegal;
   assign result_src_e  = r_ctrl.result_src;
   assign imm_src_e     = r_ctrl.imm_src;
   assign alu_ctrl_e    = r_ctrl.alu_ctrl;
   assign store_src_e   = r_ctrl.store_src;
   assign type_branch_e = r_ctrl.type_branch;
   assign load_part_e   = r_ctrl.load_part;

endmodule
